// File: rtl/microprocessor_4bit_pkg.sv
// Shared opcode constants and phase encoding for the 4-bit microprocessor.
package microprocessor_4bit_pkg;

  // Instruction phases; every instruction walks T0..T3 once.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } phase_e;

  // Opcodes live in Instr[7:4]; anything above OP_LOAD decodes as a NOP.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h4;
  localparam logic [3:0] OP_LOAD = 4'h5;

endpackage

// File: rtl/microprocessor_4bit_alu4.sv
// 4-bit add/subtract unit. Subtraction is a + ~b + 1; carry out is dropped.
module alu4 #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sub_i,
  output logic [DW-1:0] y_o
);

  logic [DW-1:0] b_eff;
  logic [DW-1:0] cin;

  // Invert the operand and inject a carry-in of one for subtraction.
  always_comb begin
    b_eff = b_i ^ {DW{sub_i}};
    cin   = {{(DW-1){1'b0}}, sub_i};
    y_o   = a_i + b_eff + cin;
  end

endmodule

// File: rtl/microprocessor_4bit.sv
// 4-bit accumulator machine: four-phase sequencer, decoder, register file
// and internal bus. Fetch in T0, Pc bump in T1, execute in T2/T3.
module microprocessor_4bit
  import microprocessor_4bit_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic            clk1,
  input  logic            MainClear,
  input  logic [DW-1:0]   DataIn,
  input  logic [2*DW-1:0] Instr,
  output logic [DW-1:0]   Pc,
  output logic [DW-1:0]   IB,
  output logic [DW-1:0]   DataOut
);

  phase_e            phase_q, phase_d;
  logic [DW-1:0]     pc_q, pc_d;
  logic [2*DW-1:0]   ir_q, ir_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic [DW-1:0]     ib;
  logic [DW-1:0]     op, imm;
  logic [DW-1:0]     alu_y;
  logic              alu_sub;

  assign op  = ir_q[2*DW-1:DW];
  assign imm = ir_q[DW-1:0];

  alu4 #(.DW(DW)) u_alu (
    .a_i   (acc_q),
    .b_i   (a_q),
    .sub_i (alu_sub),
    .y_o   (alu_y)
  );

  // Phase register; reset parks the sequencer in T0 so the next edge fetches.
  always_ff @(posedge clk1 or posedge MainClear) begin
    if (MainClear) phase_q <= T0;
    else           phase_q <= phase_d;
  end

  // Phase sequence is a fixed ring, independent of the opcode.
  always_comb begin
    phase_d = T0;
    case (phase_q)
      T0: phase_d = T1;
      T1: phase_d = T2;
      T2: phase_d = T3;
      T3: phase_d = T0;
      default: phase_d = T0;
    endcase
  end

  // Decode: pick the single bus source for this phase and the register it feeds.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    ib      = '0;
    alu_sub = (op == OP_SUB);
    case (phase_q)
      T0: ir_d = Instr;
      T1: pc_d = pc_q + 1'b1;
      T2: begin
        case (op)
          OP_ADD, OP_SUB: begin ib = imm;    a_d    = ib; end
          OP_OUT:         begin ib = acc_q;  dout_d = ib; end
          OP_IN:          begin ib = DataIn; acc_d  = ib; end
          OP_LOAD:        begin ib = imm;    acc_d  = ib; end
          default: ;
        endcase
      end
      T3: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ib    = alu_y;
          acc_d = ib;
        end
      end
      default: ;
    endcase
  end

  // Architectural registers; reset clears everything, aborting any instruction.
  always_ff @(posedge clk1 or posedge MainClear) begin
    if (MainClear) begin
      pc_q   <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign Pc      = pc_q;
  assign IB      = ib;
  assign DataOut = dout_q;

endmodule

// File: tb/tb_microprocessor_4bit.sv
// Self-checking bench: directed programs plus random programs, each instruction
// checked phase by phase against an instruction-level reference model.
module tb_microprocessor_4bit;

  logic       clk1 = 1'b0;
  logic       MainClear = 1'b1;
  logic [3:0] DataIn = '0;
  logic [7:0] Instr;
  logic [3:0] Pc, IB, DataOut;

  logic [7:0] prog [16];

  int checks = 0;
  int failures = 0;

  // Reference model state (instruction-level view of the machine).
  int m_pc, m_a, m_acc, m_dout;

  microprocessor_4bit #(.DW(4)) dut (
    .clk1      (clk1),
    .MainClear (MainClear),
    .DataIn    (DataIn),
    .Instr     (Instr),
    .Pc        (Pc),
    .IB        (IB),
    .DataOut   (DataOut)
  );

  assign Instr = prog[Pc];

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pc = 0; m_a = 0; m_acc = 0; m_dout = 0;
  endtask

  // Hold reset across a couple of edges, check the cleared outputs, release
  // just after an edge so the next edge is the T0 fetch.
  task automatic do_reset();
    MainClear = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_pc", Pc, 0);
    chk("rst_dout", DataOut, 0);
    chk("rst_ib", IB, 0);
    MainClear = 1'b0;
    model_clear();
  endtask

  // Run one instruction (4 edges); entered and left #1 after an edge in T0.
  task automatic run_instr();
    logic [7:0] ir;
    int op, imm, t2, t3;
    ir  = prog[m_pc];
    op  = int'(ir[7:4]);
    imm = int'(ir[3:0]);
    t2  = 0;
    t3  = 0;
    chk("pc_t0", Pc, m_pc);
    chk("ib_t0", IB, 0);
    @(posedge clk1); #1;
    chk("ib_t1", IB, 0);
    @(posedge clk1); #1;
    m_pc = (m_pc + 1) % 16;
    chk("pc_t2", Pc, m_pc);
    case (op)
      1: begin t2 = imm; t3 = (m_acc + imm) % 16; end
      2: begin t2 = imm; t3 = (m_acc - imm + 16) % 16; end
      3: t2 = m_acc;
      4: t2 = int'(DataIn);
      5: t2 = imm;
      default: ;
    endcase
    chk("ib_t2", IB, t2);
    @(posedge clk1); #1;
    case (op)
      1, 2: m_a = imm;
      3: m_dout = m_acc;
      4: m_acc = int'(DataIn);
      5: m_acc = imm;
      default: ;
    endcase
    chk("ib_t3", IB, t3);
    chk("dout_t3", DataOut, m_dout);
    @(posedge clk1); #1;
    if (op == 1 || op == 2) m_acc = t3;
    chk("dout_end", DataOut, m_dout);
  endtask

  task automatic fill(input logic [7:0] fillv);
    for (int i = 0; i < 16; i++) prog[i] = fillv;
  endtask

  initial begin
    fill(8'h00);
    model_clear();

    // Reset, then fetch of address 0 and Pc bump.
    prog[0] = 8'h55; prog[1] = 8'h30;
    do_reset();
    repeat (2) run_instr();
    chk("load5_out", DataOut, 5);

    // ADD with wrap-free result.
    fill(8'h00);
    prog[0] = 8'h53; prog[1] = 8'h17; prog[2] = 8'h30;
    do_reset();
    repeat (3) run_instr();
    chk("add_out", DataOut, 4'hA);

    // SUB borrow wraps; 0 - 0 stays 0.
    fill(8'h00);
    prog[0] = 8'h52; prog[1] = 8'h23; prog[2] = 8'h30;
    prog[3] = 8'h50; prog[4] = 8'h20; prog[5] = 8'h30;
    do_reset();
    repeat (3) run_instr();
    chk("sub_wrap", DataOut, 4'hF);
    repeat (3) run_instr();
    chk("sub_zero", DataOut, 0);

    // IN then OUT; opcode 0xE is a NOP.
    fill(8'h00);
    prog[0] = 8'h40; prog[1] = 8'h30; prog[2] = 8'hE7; prog[3] = 8'h30;
    do_reset();
    DataIn = 4'd9;
    repeat (4) run_instr();
    chk("in_out", DataOut, 9);

    // 16 NOPs wrap Pc to 0.
    fill(8'h00);
    do_reset();
    repeat (16) run_instr();
    chk("pc_wrap", Pc, 0);

    // Reset during ADD T2 aborts; ACC remains 0.
    fill(8'h00);
    prog[0] = 8'h57; prog[1] = 8'h30; prog[2] = 8'h15;
    do_reset();
    repeat (2) run_instr();
    chk("pre_abort", DataOut, 7);
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    chk("abort_ib_t2", IB, 5);
    MainClear = 1'b1;
    #1;
    chk("abort_pc", Pc, 0);
    chk("abort_dout", DataOut, 0);
    chk("abort_ib", IB, 0);
    fill(8'h00);
    prog[0] = 8'h30;
    do_reset();
    run_instr();
    chk("abort_acc", DataOut, 0);

    // Random programs with random DataIn, biased toward real opcodes.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] o;
        o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(0, 5));
        prog[i] = {o, 4'($urandom_range(0, 15))};
      end
      do_reset();
      for (int k = 0; k < 24; k++) begin
        DataIn = 4'($urandom_range(0, 15));
        run_instr();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
